// File: rtl/alu_nibble_serial.sv
// alu_nibble_serial: SM83-style ALU computing one 4-bit slice per clock, LSB nibble first
package sm83_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND,
    ALU_XOR, ALU_OR, ALU_CP, ALU_INC, ALU_DEC
  } alu_op_t;
  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;
endpackage

module alu_nibble_serial
  import sm83_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int HC_BIT = 3,
  parameter int KEEP_Z = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_op_t           alu_op,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  flags_t            in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output flags_t            out_flags,
  output logic              busy
);
  localparam int NIB = DATA_W / 4;
  localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
  localparam int HC_NIB = HC_BIT / 4;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  alu_op_t op;
  logic [DATA_W-1:0] a, b, res, full, mask;
  flags_t fl, flg, nflg;
  logic cy, h_r, h_now, sub, arith, last, z;
  logic [CW-1:0] cnt;
  logic [CW+1:0] sh;
  logic [3:0] an, bn, nib;
  logic [4:0] s5;

  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign result = res;
  assign out_flags = flg;

  // current nibble slice: 5-bit add/sub with chained carry, merged into the partial result
  always_comb begin
    sh = {cnt, 2'b00};
    an = 4'(a >> sh);
    bn = 4'(b >> sh);
    sub = op inside {ALU_SUB, ALU_SBC, ALU_CP, ALU_DEC};
    arith = sub || op inside {ALU_ADD, ALU_ADC, ALU_INC};
    s5 = sub ? {1'b0, an} - {1'b0, bn} - {4'b0, cy} : {1'b0, an} + {1'b0, bn} + {4'b0, cy};
    nib = op == ALU_AND ? an & bn : op == ALU_OR ? an | bn : op == ALU_XOR ? an ^ bn : arith ? s5[3:0] : an;
    mask = DATA_W'(4'hF) << sh;
    full = (res & ~mask) | (DATA_W'(nib) << sh);
    last = cnt == CW'(NIB - 1);
    h_now = cnt == CW'(HC_NIB) ? s5[4] : h_r;
    z = full == '0;
    case (op)
      ALU_ADD, ALU_ADC:          nflg = {KEEP_Z != 0 ? fl.z : z, 1'b0, h_now, s5[4]};
      ALU_SUB, ALU_SBC, ALU_CP:  nflg = {z, 1'b1, h_now, s5[4]};
      ALU_INC:                   nflg = {z, 1'b0, h_now, fl.c};
      ALU_DEC:                   nflg = {z, 1'b1, h_now, fl.c};
      ALU_AND:                   nflg = {z, 3'b010};
      ALU_OR, ALU_XOR:           nflg = {z, 3'b000};
      default:                   nflg = fl;
    endcase
  end

  // request latch, nibble sequencing and result hold until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= ALU_ADD;
      a <= '0;
      b <= '0;
      fl <= '0;
      cy <= 1'b0;
      h_r <= 1'b0;
      cnt <= '0;
      res <= '0;
      flg <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op <= alu_op;
          a <= op1;
          b <= alu_op inside {ALU_INC, ALU_DEC} ? DATA_W'(1) : op2;
          fl <= in_flags;
          cy <= alu_op inside {ALU_ADC, ALU_SBC} ? in_flags.c : 1'b0;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          res <= full;
          cy <= s5[4];
          if (cnt == CW'(HC_NIB)) h_r <= s5[4];
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            flg <= nflg;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_nibble_serial.sv
// tb_alu_nibble_serial: directed and random checks of the nibble-serial ALU at 8 and 16 bits
module tb_alu_nibble_serial;
  import sm83_pkg::*;

  typedef struct packed {
    logic [15:0] r;
    flags_t f;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, wide = 1'b0;
  alu_op_t op = ALU_ADD;
  logic [15:0] a = '0, b = '0;
  flags_t fl = '0;
  logic ir8, ov8, busy8, ir16, ov16, busy16;
  logic [7:0] r8;
  logic [15:0] r16;
  flags_t f8, f16;
  logic o_ir, o_ov, o_busy;
  logic [15:0] o_res;
  flags_t o_fl;
  exp_t sq[$];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  alu_nibble_serial #(.DATA_W(8), .HC_BIT(3), .KEEP_Z(0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~wide), .in_ready(ir8), .alu_op(op),
    .op1(a[7:0]), .op2(b[7:0]), .in_flags(fl), .out_valid(ov8), .out_ready(out_ready),
    .result(r8), .out_flags(f8), .busy(busy8)
  );

  alu_nibble_serial #(.DATA_W(16), .HC_BIT(11), .KEEP_Z(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid & wide), .in_ready(ir16), .alu_op(op),
    .op1(a), .op2(b), .in_flags(fl), .out_valid(ov16), .out_ready(out_ready),
    .result(r16), .out_flags(f16), .busy(busy16)
  );

  assign o_ir = wide ? ir16 : ir8;
  assign o_ov = wide ? ov16 : ov8;
  assign o_busy = wide ? busy16 : busy8;
  assign o_res = wide ? r16 : {8'h00, r8};
  assign o_fl = wide ? f16 : f8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model8(input alu_op_t o, input logic [7:0] x, input logic [7:0] y, input flags_t f);
    int ai, bi, ci, s;
    logic n, h, c;
    exp_t e;
    ai = int'(x);
    bi = (o == ALU_INC || o == ALU_DEC) ? 1 : int'(y);
    ci = (o == ALU_ADC || o == ALU_SBC) ? int'(f.c) : 0;
    s = ai; n = 1'b0; h = 1'b0; c = 1'b0;
    case (o)
      ALU_ADD, ALU_ADC, ALU_INC: begin
        s = ai + bi + ci; h = (ai % 16) + (bi % 16) + ci > 15; c = s > 255;
      end
      ALU_SUB, ALU_SBC, ALU_CP, ALU_DEC: begin
        s = ai - bi - ci; h = (ai % 16) < (bi % 16) + ci; c = s < 0; n = 1'b1;
      end
      ALU_AND: begin s = ai & bi; h = 1'b1; end
      ALU_OR:  s = ai | bi;
      ALU_XOR: s = ai ^ bi;
      default: s = ai;
    endcase
    if (o == ALU_INC || o == ALU_DEC) c = f.c;
    e.r = 16'(s & 255);
    e.f = {(s & 255) == 0, n, h, c};
    if (!(o inside {ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR, ALU_CP, ALU_INC, ALU_DEC})) e.f = f;
    return e;
  endfunction

  task automatic run(input bit w, input alu_op_t o, input logic [15:0] x, input logic [15:0] y,
                     input flags_t f, input logic [15:0] er, input flags_t ef, input int hold, input string tag);
    exp_t e;
    int lat;
    wide = w; op = o; a = x; b = y; fl = f; in_valid = 1'b1;
    #1;
    chk({tag, "_idle_ready"}, 32'(o_ir), 32'd1);
    sq.push_back('{er, ef});
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~x; b = ~y; fl = ~f; op = ALU_AND;
    chk({tag, "_run_busy"}, {o_busy, o_ir}, 32'b10);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!o_ov && lat < 20);
    chk({tag, "_latency"}, 32'(lat), w ? 32'd4 : 32'd2);
    e = sq.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_hold"}, {o_ov, o_ir, o_res, 4'(o_fl)}, {1'b1, 1'b0, e.r, 4'(e.f)});
    end
    in_valid = 1'b0;
    chk({tag, "_result"}, 32'(o_res), 32'(e.r));
    chk({tag, "_flags"}, 32'(o_fl), 32'(e.f));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_release"}, {o_ov, o_ir}, 32'b01);
  endtask

  initial begin
    exp_t m;
    alu_op_t ro;
    logic [7:0] rx, ry;
    flags_t rf;
    int seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset8", {ir8, ov8, busy8, r8, 4'(f8)}, {3'b100, 8'h00, 4'h0});
    chk("reset16", {ir16, ov16, busy16, r16, 4'(f16)}, {3'b100, 16'h0000, 4'h0});
    rst = 1'b0;
    @(posedge clk); #1;
    run(0, ALU_ADD, 16'h3A, 16'hC6, 4'b0000, 16'h00, 4'b1011, 0, "add_3a_c6");
    run(0, ALU_SUB, 16'h10, 16'h01, 4'b0000, 16'h0F, 4'b0110, 0, "sub_10_01");
    run(0, ALU_SBC, 16'h00, 16'h00, 4'b0001, 16'hFF, 4'b0111, 0, "sbc_00_00");
    run(0, ALU_DEC, 16'h00, 16'h55, 4'b0001, 16'hFF, 4'b0111, 0, "dec_00");
    run(0, ALU_INC, 16'hFF, 16'h55, 4'b0000, 16'h00, 4'b1010, 0, "inc_ff");
    run(0, ALU_ADC, 16'h0F, 16'h00, 4'b0001, 16'h10, 4'b0010, 0, "adc_0f");
    run(0, ALU_AND, 16'hF0, 16'h3C, 4'b0001, 16'h30, 4'b0010, 0, "and");
    run(0, ALU_XOR, 16'hAA, 16'hAA, 4'b1111, 16'h00, 4'b1000, 0, "xor");
    run(0, ALU_OR, 16'h81, 16'h42, 4'b1111, 16'hC3, 4'b0000, 0, "or");
    run(0, ALU_CP, 16'h05, 16'h05, 4'b0000, 16'h00, 4'b1100, 0, "cp_eq");
    run(0, alu_op_t'(4'hF), 16'h5A, 16'h33, 4'b1010, 16'h5A, 4'b1010, 0, "pass");
    run(0, ALU_SUB, 16'h20, 16'h31, 4'b0000, 16'hEF, 4'b0111, 5, "backpressure");
    for (int i = 0; i < 6; i++) begin
      ro = alu_op_t'($urandom_range(0, 9));
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rf = flags_t'($urandom_range(0, 15));
      m = model8(ro, rx, ry, rf);
      run(0, ro, {8'h00, rx}, {8'h00, ry}, rf, m.r, m.f, 0, "random");
    end
    run(1, ALU_ADD, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 0, "add16_0fff");
    run(1, ALU_ADD, 16'h8000, 16'h8000, 4'b0000, 16'h0000, 4'b0001, 0, "add16_8000");
    wide = 1'b0; op = ALU_ADD; a = 16'h0001; b = 16'h0001; fl = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state", {ir8, ov8, busy8, r8, 4'(f8)}, {3'b100, 8'h00, 4'h0});
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ov8) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    run(0, ALU_ADD, 16'h01, 16'h01, 4'b0000, 16'h02, 4'b0000, 0, "add_after_abort");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
